// File: rtl/mmu_client_arbiter_pkg.sv
// mmu_client_arbiter_pkg: shared mmu_top field widths and response FSM encodings.
package mmu_client_arbiter_pkg;
    localparam int REQ_ID_WIDTH        = 13;
    localparam int REQ_SIZE_TYPE_WIDTH = 8;
    localparam int ALL_PAGE_IDX_WIDTH  = 12;
    localparam int FAIL_REASON_WIDTH   = 3;
    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_HOLD = 2'd2
    } rsp_state_e;
endpackage

// File: rtl/mmu_rsp_router.sv
// mmu_rsp_router: pops one mmu_top response FIFO and steers it by id tag to a client.
module mmu_rsp_router
    import mmu_client_arbiter_pkg::*;
#(
    parameter int N     = 4,
    parameter int TAG_W = 2,
    parameter int PW    = 45
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_not_empty,
    input  logic [PW-1:0]       i_data,
    input  logic [N-1:0]        i_ready,
    output logic                o_pop,
    output logic [N-1:0]        o_valid,
    output logic [PW-TAG_W-1:0] o_bus
);
    rsp_state_e          r_state, w_next;
    logic [TAG_W-1:0]    r_port;
    logic [PW-TAG_W-1:0] r_data;
    logic                w_pop;
    always_comb begin
        w_next = r_state;
        w_pop  = 1'b0;
        case (r_state)
            R_IDLE: begin
                w_pop  = i_not_empty;
                w_next = i_not_empty ? R_WAIT : R_IDLE;
            end
            R_WAIT: w_next = R_HOLD;
            R_HOLD:
                if (i_ready[r_port]) begin
                    w_pop  = i_not_empty;
                    w_next = i_not_empty ? R_WAIT : R_IDLE;
                end
            default: w_next = R_IDLE;
        endcase
    end
    assign o_pop   = rst_n & w_pop;
    assign o_valid = (r_state == R_HOLD) ? (N'(1) << r_port) : '0;
    assign o_bus   = r_data;
    // The id sits in the top bits, so its tag is the payload MSBs.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_state <= R_IDLE;
            r_port  <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == R_WAIT) {r_port, r_data} <= i_data;
        end
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant starting at a rotating pointer.
module rr_arbiter #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] i_req,
    input  logic         i_en,
    output logic [N-1:0] o_grant,
    output logic [W-1:0] o_idx,
    output logic         o_valid
);
    logic [W-1:0] r_ptr;
    logic [W-1:0] w_idx;
    // Descending scan so the requester closest to the pointer wins.
    always_comb begin
        w_idx = r_ptr;
        for (int i = N - 1; i >= 0; i--)
            if (i_req[r_ptr + W'(i)]) w_idx = r_ptr + W'(i);
    end
    assign o_valid = i_en & (|i_req);
    assign o_grant = o_valid ? (N'(1) << w_idx) : '0;
    assign o_idx   = w_idx;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_ptr <= '0;
        else if (o_valid) r_ptr <= w_idx + W'(1);
endmodule

// File: rtl/mmu_client_arbiter.sv
// mmu_client_arbiter: shares one mmu_top between N_PORTS clients with tagged ids.
module mmu_client_arbiter
    import mmu_client_arbiter_pkg::*;
#(
    parameter int N_PORTS = 4,
    parameter int TAG_W   = $clog2(N_PORTS),
    parameter int CID_W   = REQ_ID_WIDTH - TAG_W
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic [N_PORTS-1:0]                      i_cl_alloc_valid,
    output logic [N_PORTS-1:0]                      o_cl_alloc_ready,
    input  logic [N_PORTS*CID_W-1:0]                i_cl_alloc_id,
    input  logic [N_PORTS*REQ_SIZE_TYPE_WIDTH-1:0]  i_cl_alloc_cnt,
    input  logic [N_PORTS-1:0]                      i_cl_free_valid,
    output logic [N_PORTS-1:0]                      o_cl_free_ready,
    input  logic [N_PORTS*CID_W-1:0]                i_cl_free_id,
    input  logic [N_PORTS*REQ_SIZE_TYPE_WIDTH-1:0]  i_cl_free_cnt,
    input  logic [N_PORTS*ALL_PAGE_IDX_WIDTH-1:0]   i_cl_free_idx,
    output logic [N_PORTS-1:0]                      o_cl_alloc_rsp_valid,
    input  logic [N_PORTS-1:0]                      i_cl_alloc_rsp_ready,
    output logic [CID_W+ALL_PAGE_IDX_WIDTH+1+FAIL_REASON_WIDTH+2*REQ_SIZE_TYPE_WIDTH-1:0] o_cl_alloc_rsp_bus,
    output logic [N_PORTS-1:0]                      o_cl_free_rsp_valid,
    input  logic [N_PORTS-1:0]                      i_cl_free_rsp_ready,
    output logic [CID_W+1+FAIL_REASON_WIDTH+2*REQ_SIZE_TYPE_WIDTH-1:0] o_cl_free_rsp_bus,
    output logic                                    o_m_alloc_req_submit,
    output logic [REQ_ID_WIDTH-1:0]                 o_m_alloc_req_id,
    output logic [REQ_SIZE_TYPE_WIDTH-1:0]          o_m_alloc_req_cnt,
    input  logic                                    i_m_alloc_req_fifo_full,
    output logic                                    o_m_alloc_rsp_pop,
    input  logic                                    i_m_alloc_rsp_fifo_not_empty,
    input  logic [REQ_ID_WIDTH-1:0]                 i_m_alloc_rsp_id,
    input  logic [ALL_PAGE_IDX_WIDTH-1:0]           i_m_alloc_rsp_page_idx,
    input  logic                                    i_m_alloc_rsp_fail,
    input  logic [FAIL_REASON_WIDTH-1:0]            i_m_alloc_rsp_reason,
    input  logic [REQ_SIZE_TYPE_WIDTH-1:0]          i_m_alloc_rsp_origin,
    input  logic [REQ_SIZE_TYPE_WIDTH-1:0]          i_m_alloc_rsp_actual,
    output logic                                    o_m_free_req_submit,
    output logic [REQ_ID_WIDTH-1:0]                 o_m_free_req_id,
    output logic [REQ_SIZE_TYPE_WIDTH-1:0]          o_m_free_req_cnt,
    output logic [ALL_PAGE_IDX_WIDTH-1:0]           o_m_free_req_idx,
    input  logic                                    i_m_free_req_fifo_full,
    output logic                                    o_m_free_rsp_pop,
    input  logic                                    i_m_free_rsp_fifo_not_empty,
    input  logic [REQ_ID_WIDTH-1:0]                 i_m_free_rsp_id,
    input  logic                                    i_m_free_rsp_fail,
    input  logic [FAIL_REASON_WIDTH-1:0]            i_m_free_rsp_reason,
    input  logic [REQ_SIZE_TYPE_WIDTH-1:0]          i_m_free_rsp_origin,
    input  logic [REQ_SIZE_TYPE_WIDTH-1:0]          i_m_free_rsp_actual
);
    localparam int AR_W = REQ_ID_WIDTH + ALL_PAGE_IDX_WIDTH + 1 + FAIL_REASON_WIDTH + 2*REQ_SIZE_TYPE_WIDTH;
    localparam int FR_W = REQ_ID_WIDTH + 1 + FAIL_REASON_WIDTH + 2*REQ_SIZE_TYPE_WIDTH;

    logic [CID_W-1:0]               w_a_cid [N_PORTS];
    logic [REQ_SIZE_TYPE_WIDTH-1:0] w_a_cnt [N_PORTS];
    logic [CID_W-1:0]               w_f_cid [N_PORTS];
    logic [REQ_SIZE_TYPE_WIDTH-1:0] w_f_cnt [N_PORTS];
    logic [ALL_PAGE_IDX_WIDTH-1:0]  w_f_idx [N_PORTS];
    logic [TAG_W-1:0]               w_a_idx, w_f_idx_sel;

    genvar g;
    for (g = 0; g < N_PORTS; g++) begin : g_unpack
        assign w_a_cid[g] = i_cl_alloc_id[g*CID_W +: CID_W];
        assign w_a_cnt[g] = i_cl_alloc_cnt[g*REQ_SIZE_TYPE_WIDTH +: REQ_SIZE_TYPE_WIDTH];
        assign w_f_cid[g] = i_cl_free_id[g*CID_W +: CID_W];
        assign w_f_cnt[g] = i_cl_free_cnt[g*REQ_SIZE_TYPE_WIDTH +: REQ_SIZE_TYPE_WIDTH];
        assign w_f_idx[g] = i_cl_free_idx[g*ALL_PAGE_IDX_WIDTH +: ALL_PAGE_IDX_WIDTH];
    end

    // Full is registered in mmu_top, so gating on it alone cannot overflow.
    rr_arbiter #(.N(N_PORTS), .W(TAG_W)) u_alloc_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_req   (i_cl_alloc_valid),
        .i_en    (rst_n & ~i_m_alloc_req_fifo_full),
        .o_grant (o_cl_alloc_ready),
        .o_idx   (w_a_idx),
        .o_valid (o_m_alloc_req_submit)
    );

    rr_arbiter #(.N(N_PORTS), .W(TAG_W)) u_free_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_req   (i_cl_free_valid),
        .i_en    (rst_n & ~i_m_free_req_fifo_full),
        .o_grant (o_cl_free_ready),
        .o_idx   (w_f_idx_sel),
        .o_valid (o_m_free_req_submit)
    );

    assign o_m_alloc_req_id  = o_m_alloc_req_submit ? {w_a_idx, w_a_cid[w_a_idx]} : '0;
    assign o_m_alloc_req_cnt = o_m_alloc_req_submit ? w_a_cnt[w_a_idx] : '0;
    assign o_m_free_req_id   = o_m_free_req_submit ? {w_f_idx_sel, w_f_cid[w_f_idx_sel]} : '0;
    assign o_m_free_req_cnt  = o_m_free_req_submit ? w_f_cnt[w_f_idx_sel] : '0;
    assign o_m_free_req_idx  = o_m_free_req_submit ? w_f_idx[w_f_idx_sel] : '0;

    mmu_rsp_router #(.N(N_PORTS), .TAG_W(TAG_W), .PW(AR_W)) u_alloc_rsp (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_not_empty (i_m_alloc_rsp_fifo_not_empty),
        .i_data      ({i_m_alloc_rsp_id, i_m_alloc_rsp_page_idx, i_m_alloc_rsp_fail,
                       i_m_alloc_rsp_reason, i_m_alloc_rsp_origin, i_m_alloc_rsp_actual}),
        .i_ready     (i_cl_alloc_rsp_ready),
        .o_pop       (o_m_alloc_rsp_pop),
        .o_valid     (o_cl_alloc_rsp_valid),
        .o_bus       (o_cl_alloc_rsp_bus)
    );

    mmu_rsp_router #(.N(N_PORTS), .TAG_W(TAG_W), .PW(FR_W)) u_free_rsp (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_not_empty (i_m_free_rsp_fifo_not_empty),
        .i_data      ({i_m_free_rsp_id, i_m_free_rsp_fail, i_m_free_rsp_reason,
                       i_m_free_rsp_origin, i_m_free_rsp_actual}),
        .i_ready     (i_cl_free_rsp_ready),
        .o_pop       (o_m_free_rsp_pop),
        .o_valid     (o_cl_free_rsp_valid),
        .o_bus       (o_cl_free_rsp_bus)
    );
endmodule
